// File: rtl/cargador_matrices.sv
// Stream-to-matrix loader: packs A (row-major) then B (column-major) for the multiplier.
// Optional macro CARGADOR_SOF_EN adds in_sof to resynchronise framing at A element 0.
module cargador_matrices #(
    parameter int unsigned Bit = 3,
    parameter int unsigned M   = 4,
    parameter int unsigned N   = 2,
    parameter int unsigned P   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [Bit-1:0]     in_data,
    input  logic               in_valid,
`ifdef CARGADOR_SOF_EN
    input  logic               in_sof,
`endif
    output logic               in_ready,
    output logic [N*M*Bit-1:0] mat_a,
    output logic [M*P*Bit-1:0] mat_b,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned ElemsA   = N * M;
    localparam int unsigned ElemsB   = M * P;
    localparam int unsigned MaxElems = (ElemsA > ElemsB) ? ElemsA : ElemsB;
    localparam int unsigned IdxW     = (MaxElems > 1) ? $clog2(MaxElems) : 1;

    localparam logic [IdxW-1:0] LastA = IdxW'(ElemsA - 1);
    localparam logic [IdxW-1:0] LastB = IdxW'(ElemsB - 1);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StFull
    } state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [N*M*Bit-1:0]   mat_a_q, mat_a_d;
    logic [M*P*Bit-1:0]   mat_b_q, mat_b_d;
    logic                 accept;
    int unsigned          idx_int;

    // Handshake outputs depend on registered state only (plus the reset gate).
    assign in_ready  = (state_q != StFull) && !rst;
    assign out_valid = (state_q == StFull);
    assign accept    = in_valid && in_ready;
    assign idx_int   = 32'(idx_q);

    assign mat_a = mat_a_q;
    assign mat_b = mat_b_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;

        unique case (state_q)
            StLoadA: begin
                if (accept) begin
                    for (int unsigned e = 0; e < ElemsA; e++) begin
                        if (idx_int == e) begin
                            mat_a_d[e*Bit +: Bit] = in_data;
                        end
                    end
                    if (idx_q == LastA) begin
                        state_d = StLoadB;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StLoadB: begin
                if (accept) begin
                    for (int unsigned e = 0; e < ElemsB; e++) begin
                        if (idx_int == e) begin
                            mat_b_d[e*Bit +: Bit] = in_data;
                        end
                    end
                    if (idx_q == LastB) begin
                        state_d = StFull;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StFull: begin
                if (out_ready) begin
                    state_d = StLoadA;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StLoadA;
                idx_d   = '0;
            end
        endcase

`ifdef CARGADOR_SOF_EN
        // Start-of-frame overrides the counted position; B contents are left intact.
        if (accept && in_sof) begin
            mat_a_d            = mat_a_q;
            mat_b_d            = mat_b_q;
            mat_a_d[Bit-1:0]   = in_data;
            if (ElemsA == 1) begin
                state_d = StLoadB;
                idx_d   = '0;
            end else begin
                state_d = StLoadA;
                idx_d   = IdxW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadA;
            idx_q   <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
        end
    end

endmodule

// File: tb/tb_cargador_matrices.sv
// Directed self-checking bench for cargador_matrices (Bit=3, M=4, N=2, P=2).
module tb_cargador_matrices;

    localparam int unsigned BitW = 3;
    localparam int unsigned MD   = 4;
    localparam int unsigned ND   = 2;
    localparam int unsigned PD   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mat_a;
    logic [23:0] mat_b;
    logic        out_valid;
    logic        out_ready;
`ifdef CARGADOR_SOF_EN
    logic        in_sof;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cargador_matrices #(
        .Bit (BitW),
        .M   (MD),
        .N   (ND),
        .P   (PD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef CARGADOR_SOF_EN
        .in_sof    (in_sof),
`endif
        .in_ready  (in_ready),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_data  = 3'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Product C[i][j] that the downstream multiplier would form from the buses.
    function automatic int prod(input logic [23:0] a, input logic [23:0] b,
                                input int i, input int j);
        int s = 0;
        for (int k = 0; k < int'(MD); k++) begin
            s += int'(a[(i*MD+k)*BitW +: BitW]) * int'(b[(j*MD+k)*BitW +: BitW]);
        end
        return s;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 3'd3;
        out_ready = 1'b0;
`ifdef CARGADOR_SOF_EN
        in_sof    = 1'b0;
`endif

        // Reset held two cycles with in_valid high
        tick();
        check("rst_in_ready_c1", 64'(in_ready), 64'd0);
        tick();
        check("rst_in_ready_c2", 64'(in_ready), 64'd0);
        check("rst_mat_a", 64'(mat_a), 64'd0);
        check("rst_mat_b", 64'(mat_b), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Continuous frame of ones
        for (int i = 0; i < 15; i++) send(1);
        check("f1_ov_before_last", 64'(out_valid), 64'd0);
        send(1);
        check("f1_out_valid", 64'(out_valid), 64'd1);
        check("f1_in_ready", 64'(in_ready), 64'd0);
        check("f1_mat_a", 64'(mat_a), 64'o11111111);
        check("f1_mat_b", 64'(mat_b), 64'o11111111);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check("f1_prod", 64'(prod(mat_a, mat_b, i, j)), 64'd4);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("f1_release_ov", 64'(out_valid), 64'd0);
        check("f1_release_ir", 64'(in_ready), 64'd1);
        check("f1_buffer_kept", 64'(mat_a), 64'o11111111);

        // Packing: A = 0..7, B = 7..0
        send(0);
        check("f2_single_elem", 64'(mat_a), 64'o11111110);
        for (int i = 1; i < 8; i++) send(i);
        check("f2_mat_a_done", 64'(mat_a), 64'o76543210);
        check("f2_mat_b_old", 64'(mat_b), 64'o11111111);
        check("f2_ov_mid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 8; i++) send(7 - i);
        check("f2_out_valid", 64'(out_valid), 64'd1);
        check("f2_mat_a", 64'(mat_a), 64'o76543210);
        check("f2_mat_b", 64'(mat_b), 64'o01234567);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Bubbles mid-A
        for (int i = 0; i < 4; i++) send(2);
        tick();
        tick();
        tick();
        check("f3_bubble_mat_a", 64'(mat_a), 64'o76542222);
        for (int i = 0; i < 4; i++) send(2);
        for (int i = 0; i < 7; i++) send(3);
        check("f3_ov_at_15", 64'(out_valid), 64'd0);
        send(3);
        check("f3_ov_at_16", 64'(out_valid), 64'd1);

        // Backpressure while FULL
        in_valid = 1'b1;
        in_data  = 3'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("f3_hold_in_ready", 64'(in_ready), 64'd0);
            check("f3_hold_out_valid", 64'(out_valid), 64'd1);
        end
        check("f3_hold_mat_a", 64'(mat_a), 64'o22222222);
        check("f3_hold_mat_b", 64'(mat_b), 64'o33333333);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("f3_release_ov", 64'(out_valid), 64'd0);
        check("f3_release_ir", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("f3_next_a0", 64'(mat_a), 64'o22222225);

        // Mid-load reset after five A elements
        for (int i = 0; i < 4; i++) send(6);
        check("f4_partial_a", 64'(mat_a), 64'o22266665);
        rst = 1'b1;
        #1;
        check("f4_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("f4_rst_mat_a", 64'(mat_a), 64'd0);
        check("f4_rst_mat_b", 64'(mat_b), 64'd0);
        check("f4_rst_ov", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("f4_post_rst_ir", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) send((i + 1) % 8);
        for (int i = 0; i < 7; i++) send(4);
        check("f4_ov_at_15", 64'(out_valid), 64'd0);
        send(4);
        check("f4_out_valid", 64'(out_valid), 64'd1);
        check("f4_mat_a", 64'(mat_a), 64'o07654321);
        check("f4_mat_b", 64'(mat_b), 64'o44444444);
        check("f4_prod_00", 64'(prod(mat_a, mat_b, 0, 0)), 64'd40);
        check("f4_prod_11", 64'(prod(mat_a, mat_b, 1, 1)), 64'd72);

`ifdef CARGADOR_SOF_EN
        // Start-of-frame during B resynchronises to A index 1
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1);
        send(0);
        send(0);
        in_sof = 1'b1;
        send(6);
        in_sof = 1'b0;
        check("sof_mat_a", 64'(mat_a), 64'o11111116);
        check("sof_mat_b_kept", 64'(mat_b), 64'o44444400);
        check("sof_ov", 64'(out_valid), 64'd0);
        for (int i = 0; i < 7; i++) send(3);
        check("sof_mat_a_full", 64'(mat_a), 64'o33333336);
        check("sof_mat_b_untouched", 64'(mat_b), 64'o44444400);
        for (int i = 0; i < 7; i++) send(5);
        check("sof_ov_at_14", 64'(out_valid), 64'd0);
        send(5);
        check("sof_ov_at_15", 64'(out_valid), 64'd1);
        check("sof_mat_b", 64'(mat_b), 64'o55555555);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
